booth_mul_param: RTL



---
 rtl/multdiv_pkg.sv | 27 ++
 rtl/booth_r4_encoder.sv | 24 ++
 rtl/booth_mul_param.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the processor's multdiv unit.
//   booth_op_e  : radix-4 Booth partial-product selections
//   mul_state_e : multiplier control states
//   booth_steps : number of radix-4 steps for a given operand width
package multdiv_pkg;

  typedef enum logic [2:0] {
    OP_ZERO,
    OP_ADD1,
    OP_ADD2,
    OP_SUB1,
    OP_SUB2
  } booth_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_e;

  // Operands are extended by two bits so that unsigned values become
  // non-negative two's-complement numbers; that costs one extra step.
  function automatic int booth_steps(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder (purely combinational).
//   bits : multiplier window {b[i+1], b[i], b[i-1]}
//   op   : partial product to add to the accumulator
module booth_r4_encoder
  import multdiv_pkg::*;
(
  input  logic [2:0] bits,
  output booth_op_e  op
);

  // NOTE: assigning a default before the case keeps every path driven,
  // so no latch is inferred for op.
  always_comb begin
    op = OP_ZERO;
    case (bits)
      3'b001, 3'b010: op = OP_ADD1;
      3'b011:         op = OP_ADD2;
      3'b100:         op = OP_SUB2;
      3'b101, 3'b110: op = OP_SUB1;
      default:        op = OP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_param.sv
// Multi-cycle radix-4 Booth multiplier with start/ready handshake.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   ctrl_MULT        : start request (accepted in IDLE and DONE)
//   ctrl_abort       : cancels an operation in RUN
//   ctrl_signed      : operand mode, sampled with ctrl_MULT
//   multiplicand     : operand A, latched at start
//   multiplier       : operand B, latched at start
//   data_result      : product bits [WIDTH-1:0]
//   data_result_hi   : product bits [2*WIDTH-1:WIDTH]
//   data_resultRDY   : one-cycle completion pulse
//   data_exception   : product does not fit in WIDTH bits
//   busy             : operation in flight
module booth_mul_param
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_abort,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  localparam int N  = booth_steps(WIDTH);
  localparam int XW = WIDTH + 2;        // extended operand width
  localparam int HW = WIDTH + 4;        // high accumulator, holds +-2M safely
  localparam int FW = HW + XW + 1;      // whole product register
  localparam int CW = $clog2(N + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_mul_param: WIDTH must be even and >= 4");
  end

  function automatic logic [XW-1:0] extend(input logic [WIDTH-1:0] v,
                                           input logic             s);
    return {{2{s & v[WIDTH-1]}}, v};
  endfunction

  mul_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XW-1:0]   mcand_q;
  logic            signed_q;
  logic [HW-1:0]   acc_hi;
  logic [XW-1:0]   acc_lo;
  logic            acc_lsb;

  booth_op_e       op;
  logic [HW-1:0]   m_ext;
  logic [HW-1:0]   m_dbl;
  logic [HW-1:0]   sum;
  logic [FW-1:0]   full;
  logic [FW-1:0]   shifted;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH:0]  sign_window;
  logic            exc_nxt;

  booth_r4_encoder u_enc (
    .bits ({acc_lo[1:0], acc_lsb}),
    .op   (op)
  );

  assign m_ext = {{2{mcand_q[XW-1]}}, mcand_q};
  assign m_dbl = {m_ext[HW-2:0], 1'b0};

  always_comb begin
    sum = acc_hi;
    case (op)
      OP_ADD1: sum = acc_hi + m_ext;
      OP_ADD2: sum = acc_hi + m_dbl;
      OP_SUB1: sum = acc_hi - m_ext;
      OP_SUB2: sum = acc_hi - m_dbl;
      default: sum = acc_hi;
    endcase
  end

  assign full    = {sum, acc_lo, acc_lsb};
  assign shifted = {{2{full[FW-1]}}, full[FW-1:2]};

  // After the final step the product sits just above the implicit LSB.
  assign prod_lo     = shifted[WIDTH:1];
  assign prod_hi     = shifted[2*WIDTH:WIDTH+1];
  assign sign_window = shifted[2*WIDTH:WIDTH];
  assign exc_nxt     = signed_q ? !((&sign_window) || !(|sign_window))
                                : (|prod_hi);

  // NOTE: all state, including the datapath registers, is cleared on reset
  // so a reset mid-operation leaves nothing stale behind.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      signed_q       <= 1'b0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      acc_lsb        <= 1'b0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // A start beats a simultaneous abort here.
          if (ctrl_MULT) begin
            mcand_q  <= extend(multiplicand, ctrl_signed);
            signed_q <= ctrl_signed;
            acc_hi   <= '0;
            acc_lo   <= extend(multiplier, ctrl_signed);
            acc_lsb  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= RUN;
            busy     <= 1'b1;
          end else begin
            state_q  <= IDLE;
            busy     <= 1'b0;
          end
        end
        RUN: begin
          if (ctrl_abort) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            acc_hi  <= shifted[FW-1 -: HW];
            acc_lo  <= shifted[XW:1];
            acc_lsb <= shifted[0];
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              state_q        <= DONE;
              data_result    <= prod_lo;
              data_result_hi <= prod_hi;
              data_exception <= exc_nxt;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
